// File: rtl/sync_hs_dst.sv
// sync_hs_dst: destination side of a 4-phase req/ack word transfer into the clk domain.
// Waits for a settled request, captures the word, delivers it on valid/ready, then acks.
module sync_hs_dst #(
    parameter int DATA_WIDTH     = 32,
    parameter int SETTLE_CYCLES  = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_sync,
    input  logic [DATA_WIDTH-1:0] xfer_data,
    output logic                  ack,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic                  out_ready,
    output logic [15:0]           xfer_cnt,
    output logic                  stuck_err
);
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {WAIT_LOW, IDLE, SETTLE, PRESENT, ACK} state_t;

    state_t                state_q, state_d;
    logic [3:0]            set_cnt_q, set_cnt_d;
    logic [TW-1:0]         to_cnt_q, to_cnt_d;
    logic                  ack_q, ack_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [15:0]           xfer_cnt_q, xfer_cnt_d;
    logic                  stuck_err_q, stuck_err_d;

    always_comb begin
        state_d     = state_q;
        set_cnt_d   = set_cnt_q;
        to_cnt_d    = to_cnt_q;
        ack_d       = ack_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        xfer_cnt_d  = xfer_cnt_q;
        stuck_err_d = stuck_err_q;
        case (state_q)
            // a request still high at reset release must not count as new
            WAIT_LOW: if (!req_sync) state_d = IDLE;
            IDLE: if (req_sync) begin
                state_d   = SETTLE;
                set_cnt_d = 4'(SETTLE_CYCLES - 1);
            end
            SETTLE: if (!req_sync) state_d = IDLE;
            else if (set_cnt_q == 4'd0) begin
                out_data_d  = xfer_data;
                out_valid_d = 1'b1;
                state_d     = PRESENT;
            end else set_cnt_d = set_cnt_q - 4'd1;
            PRESENT: if (out_ready) begin
                out_valid_d = 1'b0;
                ack_d       = 1'b1;
                xfer_cnt_d  = xfer_cnt_q + 16'd1;
                to_cnt_d    = '0;
                state_d     = ACK;
            end
            ACK: begin
                if (to_cnt_q != TW'(TIMEOUT_CYCLES - 1)) to_cnt_d = to_cnt_q + TW'(1);
                if (!req_sync) begin
                    ack_d   = 1'b0;
                    state_d = IDLE;
                end else if (to_cnt_d == TW'(TIMEOUT_CYCLES - 1)) stuck_err_d = 1'b1;
            end
            default: state_d = WAIT_LOW;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= WAIT_LOW;
            set_cnt_q   <= '0;
            to_cnt_q    <= '0;
            ack_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            xfer_cnt_q  <= '0;
            stuck_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            set_cnt_q   <= set_cnt_d;
            to_cnt_q    <= to_cnt_d;
            ack_q       <= ack_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            xfer_cnt_q  <= xfer_cnt_d;
            stuck_err_q <= stuck_err_d;
        end
    end

    assign ack       = ack_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign xfer_cnt  = xfer_cnt_q;
    assign stuck_err = stuck_err_q;
endmodule

// File: tb/tb_sync_hs_dst.sv
// tb_sync_hs_dst: directed and randomized transfers checked against a transaction-level timing model.
module tb_sync_hs_dst;
    localparam int S = 2;
    localparam int T = 16;

    logic        clk = 1'b0;
    logic        reset, req_sync, out_ready, ack, out_valid, stuck_err;
    logic [31:0] xfer_data, out_data;
    logic [15:0] xfer_cnt;

    int          vectors = 0;
    int          errors  = 0;
    logic [15:0] cnt_m;
    logic [31:0] data_m;
    logic        stuck_m;

    always #5 clk = ~clk;

    sync_hs_dst #(.DATA_WIDTH(32), .SETTLE_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .reset(reset), .req_sync(req_sync), .xfer_data(xfer_data),
        .ack(ack), .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .xfer_cnt(xfer_cnt), .stuck_err(stuck_err)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_w(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset;
        reset = 1'b1;
        step;
        step;
        reset = 1'b0;
        cnt_m = '0;
        data_m = '0;
        stuck_m = 1'b0;
    endtask

    task automatic check_all(input string tag, input logic v, input logic a);
        chk_b({tag, "_valid"}, out_valid, v);
        chk_b({tag, "_ack"}, ack, a);
        chk_w({tag, "_data"}, out_data, data_m);
        chk_w({tag, "_cnt"}, 32'(xfer_cnt), 32'(cnt_m));
        chk_b({tag, "_stuck"}, stuck_err, stuck_m);
    endtask

    // req rises before cycle 1; valid over S+1..S+1+rd, ack from S+2+rd for hold cycles
    task automatic xfer(input logic [31:0] d, input int rd, input int hold);
        int a;
        a = S + 2 + rd;
        xfer_data = d;
        req_sync = 1'b1;
        out_ready = (1 >= a);
        for (int c = 1; c <= a + hold; c++) begin
            step;
            if (c == S + 1) data_m = d;
            if (c == a) cnt_m = cnt_m + 16'd1;
            if (c - a == T - 1 && c < a + hold) stuck_m = 1'b1;
            check_all("xfer", c >= S + 1 && c <= S + 1 + rd, c >= a && c < a + hold);
            out_ready = (c + 1 >= a);
            if (c == a + hold - 1) req_sync = 1'b0;
        end
        out_ready = 1'b0;
    endtask

    task automatic glitch(input int g);
        xfer_data = $urandom;
        req_sync = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < g; c++) step;
        req_sync = 1'b0;
        for (int c = 0; c < S + 3; c++) begin
            step;
            check_all("glitch", 1'b0, 1'b0);
        end
        out_ready = 1'b0;
    endtask

    initial begin
        req_sync = 1'b0;
        out_ready = 1'b0;
        xfer_data = '0;
        do_reset;
        check_all("reset", 1'b0, 1'b0);
        step;

        xfer(32'hDEADBEEF, 0, 3);
        xfer(32'h0123_4567, 10, 2);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 4) == 0) glitch($urandom_range(1, S));
            xfer($urandom, $urandom_range(0, 6), $urandom_range(1, 5));
        end

        // stuck source: sticky error survives later clean transfers
        xfer($urandom, 1, T + 4);
        xfer($urandom, 0, 2);
        chk_b("stuck_sticky", stuck_err, 1'b1);

        // stale request held through reset release
        req_sync = 1'b1;
        do_reset;
        for (int c = 0; c < 6; c++) begin
            step;
            check_all("stale", 1'b0, 1'b0);
        end
        req_sync = 1'b0;
        step;
        xfer($urandom, 2, 2);

        // async reset while presenting the word
        xfer($urandom, 0, 1);
        xfer_data = $urandom;
        req_sync = 1'b1;
        for (int c = 0; c < S + 1; c++) step;
        chk_b("pre_rst_valid", out_valid, 1'b1);
        #2 reset = 1'b1;
        #1;
        cnt_m = '0;
        data_m = '0;
        stuck_m = 1'b0;
        check_all("arst_present", 1'b0, 1'b0);
        step;
        reset = 1'b0;
        req_sync = 1'b0;
        step;

        // async reset while acking
        xfer($urandom, 0, 1);
        xfer_data = $urandom;
        req_sync = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < S + 2; c++) step;
        chk_b("pre_rst_ack", ack, 1'b1);
        #2 reset = 1'b1;
        #1;
        cnt_m = '0;
        data_m = '0;
        check_all("arst_ack", 1'b0, 1'b0);
        step;
        reset = 1'b0;
        req_sync = 1'b0;
        out_ready = 1'b0;
        step;
        xfer($urandom, 1, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
